ip_sequencer: RTL and testbench

//  Fetch/branch controller for the 16-bit instruction-pointer register (load-or-increment IP).

---
 rtl/ip_sequencer_if.sv | 30 +++
 rtl/ip_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ip_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ip_sequencer_if.sv
// Port bundle for ip_sequencer: IP-register control, instruction-fetch port and decode handshake.
// The master modport is the sequencer's view; the slave modport is the surrounding system's view.
interface ip_sequencer_if #(
  parameter int AW = 16
);
  logic [AW-1:0] ip_q;
  logic          ip_ena;
  logic          ip_sel;
  logic [AW-1:0] ip_d;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_data;
  logic [15:0]   instr;
  logic          instr_valid;
  logic [1:0]    cmd;
  logic [AW-1:0] cmd_target;
  logic          cmd_valid;
  logic          fault;

  modport master (
    input  ip_q, mem_ack, mem_data, cmd, cmd_target, cmd_valid,
    output ip_ena, ip_sel, ip_d, mem_req, mem_addr, instr, instr_valid, fault
  );

  modport slave (
    output ip_q, mem_ack, mem_data, cmd, cmd_target, cmd_valid,
    input  ip_ena, ip_sel, ip_d, mem_req, mem_addr, instr, instr_valid, fault
  );
endinterface

// File: rtl/ip_sequencer.sv
// Fetch/branch controller for a load-or-increment instruction-pointer register.
// Fetches one word per instruction, then applies NEXT/JUMP/CALL/RET using an internal return stack.
module ip_sequencer #(
  parameter int AW    = 16,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  ip_sequencer_if.master bus
);

  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = IW + 1;

  localparam logic [SPW-1:0] SP_FULL  = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_EMPTY = SPW'(0);
  localparam logic [SPW-1:0] SP_ONE   = SPW'(1);
  localparam logic [IW-1:0]  IDX_ONE  = IW'(1);
  localparam logic [AW-1:0]  IP_ONE   = AW'(1);

  localparam logic [1:0] CMD_NEXT = 2'b00;
  localparam logic [1:0] CMD_JUMP = 2'b01;
  localparam logic [1:0] CMD_CALL = 2'b10;
  localparam logic [1:0] CMD_RET  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   instr_q, instr_d;
  logic          instr_valid_q, instr_valid_d;
  logic          ip_ena_q, ip_ena_d;
  logic          ip_sel_q, ip_sel_d;
  logic [AW-1:0] ip_d_q, ip_d_d;
  logic          mem_req_q, mem_req_d;
  logic          fault_q, fault_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [AW-1:0] stack_q [DEPTH];
  logic [AW-1:0] stack_d [DEPTH];

  logic [IW-1:0] push_idx_s;
  logic [IW-1:0] pop_idx_s;
  logic          stack_err_s;

  assign push_idx_s  = sp_q[IW-1:0];
  assign pop_idx_s   = push_idx_s - IDX_ONE;
  assign stack_err_s = ((bus.cmd == CMD_CALL) && (sp_q == SP_FULL)) ||
                       ((bus.cmd == CMD_RET)  && (sp_q == SP_EMPTY));

  // Next state, stack update and next values of every registered output.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    ip_sel_d = 1'b0;
    ip_d_d   = ip_d_q;
    sp_d     = sp_q;
    stack_d  = stack_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.mem_ack) begin
          instr_d = bus.mem_data;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (!bus.cmd_valid) begin
          state_d = ST_DECODE;
        end else if (stack_err_s) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_UPDATE;
          case (bus.cmd)
            CMD_NEXT: begin
              ip_sel_d = 1'b0;
            end
            CMD_JUMP: begin
              ip_sel_d = 1'b1;
              ip_d_d   = bus.cmd_target;
            end
            CMD_CALL: begin
              // Return address wraps naturally at the top of the address space.
              ip_sel_d            = 1'b1;
              ip_d_d              = bus.cmd_target;
              stack_d[push_idx_s] = bus.ip_q + IP_ONE;
              sp_d                = sp_q + SP_ONE;
            end
            CMD_RET: begin
              ip_sel_d = 1'b1;
              ip_d_d   = stack_q[pop_idx_s];
              sp_d     = sp_q - SP_ONE;
            end
            default: begin
              ip_sel_d = 1'b0;
            end
          endcase
        end
      end
      ST_UPDATE: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they behave as Moore outputs of state_q.
    mem_req_d     = (state_d == ST_FETCH);
    ip_ena_d      = (state_d == ST_UPDATE);
    instr_valid_d = (state_q == ST_FETCH) && (state_d == ST_DECODE);
    fault_d       = fault_q || (state_d == ST_HALT);
  end

  // State, output and return-stack registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      instr_q       <= 16'h0000;
      instr_valid_q <= 1'b0;
      ip_ena_q      <= 1'b0;
      ip_sel_q      <= 1'b0;
      ip_d_q        <= {AW{1'b0}};
      mem_req_q     <= 1'b0;
      fault_q       <= 1'b0;
      sp_q          <= SP_EMPTY;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= {AW{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      ip_ena_q      <= ip_ena_d;
      ip_sel_q      <= ip_sel_d;
      ip_d_q        <= ip_d_d;
      mem_req_q     <= mem_req_d;
      fault_q       <= fault_d;
      sp_q          <= sp_d;
      stack_q       <= stack_d;
    end
  end

  // The fetch address must track IP_Q in the same cycle the IP register updates.
  assign bus.mem_addr    = mem_req_q ? bus.ip_q : {AW{1'b0}};
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.ip_ena      = ip_ena_q;
  assign bus.ip_sel      = ip_sel_q;
  assign bus.ip_d        = ip_d_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_ip_sequencer.sv
// Directed bench for ip_sequencer: an IP register and memory responder around the DUT,
// a transaction-level model (expected IP plus a return-address queue) and a per-cycle checker.
module tb_ip_sequencer;

  localparam int TB_DEPTH = 4;
  localparam logic [1:0] C_NEXT = 2'b00;
  localparam logic [1:0] C_JUMP = 2'b01;
  localparam logic [1:0] C_CALL = 2'b10;
  localparam logic [1:0] C_RET  = 2'b11;

  logic        clk;
  logic        rst;
  logic [15:0] ip_reg;
  logic [15:0] ip_init;

  int n_vec;
  int n_err;

  logic [15:0] model_ip;
  logic [15:0] model_stk [$];
  logic        exp_sel_m;
  logic [15:0] exp_d_m;

  logic [15:0] fa;
  logic [15:0] ud;

  ip_sequencer_if #(.AW(16)) bus ();

  ip_sequencer #(.AW(16), .DEPTH(TB_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The instruction-pointer register the sequencer controls.
  always @(posedge clk or posedge rst) begin
    if (rst) ip_reg <= ip_init;
    else if (bus.ip_ena) ip_reg <= bus.ip_sel ? bus.ip_d : ip_reg + 16'd1;
  end
  assign bus.ip_q = ip_reg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle invariants and update contents against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req) check("cyc_mem_addr", {16'h0, bus.mem_addr}, {16'h0, ip_reg});
      check("cyc_ena_req_excl", {31'd0, bus.ip_ena & bus.mem_req}, 32'd0);
      if (bus.fault) check("cyc_fault_quiet", {30'd0, bus.ip_ena, bus.mem_req}, 32'd0);
      if (bus.ip_ena) begin
        check("cyc_ip_sel", {31'd0, bus.ip_sel}, {31'd0, exp_sel_m});
        if (exp_sel_m) check("cyc_ip_d", {16'h0, bus.ip_d}, {16'h0, exp_d_m});
      end
    end
  end

  task automatic reset_dut(input logic [15:0] init);
    rst = 1'b1;
    ip_init = init;
    model_ip = init;
    model_stk.delete();
    bus.mem_ack = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("idle_ip_ena", {31'd0, bus.ip_ena}, 32'd0);
    check("idle_ivalid", {31'd0, bus.instr_valid}, 32'd0);
    check("idle_fault", {31'd0, bus.fault}, 32'd0);
    check("idle_instr", {16'h0, bus.instr}, 32'd0);
    check("idle_addr", {16'h0, bus.mem_addr}, 32'd0);
    @(negedge clk);
    check("first_req", {31'd0, bus.mem_req}, 32'd1);
  endtask

  // One fetch+decode+update transaction; returns fetch address and the IP_D seen in UPDATE.
  task automatic do_instr(input logic [15:0] data, input logic [1:0] cmd,
                          input logic [15:0] tgt, input int gap,
                          output logic [15:0] fetch_addr, output logic [15:0] upd_d);
    int n;
    logic exp_fault;
    logic [15:0] new_ip;
    n = 0;
    while (!bus.mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_req_seen", {31'd0, bus.mem_req}, 32'd1);
    check("fetch_addr", {16'h0, bus.mem_addr}, {16'h0, model_ip});
    fetch_addr = bus.mem_addr;
    bus.mem_data = data;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.mem_data = 16'hDEAD;
    check("instr_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("instr", {16'h0, bus.instr}, {16'h0, data});
    check("req_drop", {31'd0, bus.mem_req}, 32'd0);
    for (int g = 0; g < gap; g++) begin
      bus.mem_ack = 1'b1;
      bus.mem_data = 16'hBEEF;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      check("gap_ivalid", {31'd0, bus.instr_valid}, 32'd0);
      check("gap_instr", {16'h0, bus.instr}, {16'h0, data});
      check("gap_ena", {31'd0, bus.ip_ena}, 32'd0);
    end
    exp_fault = ((cmd == C_CALL) && (model_stk.size() == TB_DEPTH)) ||
                ((cmd == C_RET) && (model_stk.size() == 0));
    new_ip = model_ip;
    exp_sel_m = 1'b0;
    exp_d_m = 16'h0000;
    if (!exp_fault) begin
      case (cmd)
        C_NEXT: new_ip = model_ip + 16'd1;
        C_JUMP: begin exp_sel_m = 1'b1; new_ip = tgt; end
        C_CALL: begin exp_sel_m = 1'b1; new_ip = tgt; model_stk.push_back(model_ip + 16'd1); end
        default: begin exp_sel_m = 1'b1; new_ip = model_stk.pop_back(); end
      endcase
      exp_d_m = new_ip;
    end
    bus.cmd = cmd;
    bus.cmd_target = tgt;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    check("upd_ena", {31'd0, bus.ip_ena}, {31'd0, !exp_fault});
    check("upd_fault", {31'd0, bus.fault}, {31'd0, exp_fault});
    upd_d = bus.ip_d;
    // Left high through UPDATE: a command outside DECODE must be ignored.
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("post_ena", {31'd0, bus.ip_ena}, 32'd0);
    check("post_req", {31'd0, bus.mem_req}, {31'd0, !exp_fault});
    if (!exp_fault) check("post_addr", {16'h0, bus.mem_addr}, {16'h0, new_ip});
    model_ip = new_ip;
  endtask

  task automatic check_halted(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("halt_fault", {31'd0, bus.fault}, 32'd1);
      check("halt_req", {31'd0, bus.mem_req}, 32'd0);
      check("halt_ena", {31'd0, bus.ip_ena}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    ip_init = 16'h0000;
    bus.mem_ack = 1'b0;
    bus.mem_data = 16'h0000;
    bus.cmd = 2'b00;
    bus.cmd_target = 16'h0000;
    bus.cmd_valid = 1'b0;
    exp_sel_m = 1'b0;
    exp_d_m = 16'h0000;

    // Basic fetch, NEXT, JUMP, CALL/RET round trip, RET underflow.
    reset_dut(16'h0000);
    do_instr(16'h1234, C_NEXT, 16'h0000, 0, fa, ud);
    check("t1_addr", {16'h0, fa}, 32'h0000_0000);
    do_instr(16'h5555, C_JUMP, 16'h0010, 2, fa, ud);
    check("t2_addr", {16'h0, fa}, 32'h0000_0001);
    check("t2_jump_d", {16'h0, ud}, 32'h0000_0010);
    do_instr(16'hCA11, C_CALL, 16'h0200, 1, fa, ud);
    check("t3_call_addr", {16'h0, fa}, 32'h0000_0010);
    check("t3_call_d", {16'h0, ud}, 32'h0000_0200);
    do_instr(16'h0000, C_NEXT, 16'h0000, 0, fa, ud);
    do_instr(16'h4E7F, C_RET, 16'h0000, 0, fa, ud);
    check("t3_ret_addr", {16'h0, fa}, 32'h0000_0201);
    check("t3_ret_d", {16'h0, ud}, 32'h0000_0011);
    do_instr(16'h4E7F, C_RET, 16'h0000, 0, fa, ud);
    check_halted(5);

    // Stack overflow on the fifth nested CALL.
    reset_dut(16'h0000);
    for (int i = 0; i < 5; i++) begin
      do_instr(16'h00C0, C_CALL, 16'h0100 + 16'(i), 0, fa, ud);
    end
    check("t4_fourth_pc", {16'h0, model_ip}, 32'h0000_0103);
    check_halted(6);

    // Wrap at the top of the address space.
    reset_dut(16'hFFFF);
    do_instr(16'h7777, C_NEXT, 16'h0000, 0, fa, ud);
    check("t5_top_addr", {16'h0, fa}, 32'h0000_FFFF);
    do_instr(16'h7778, C_NEXT, 16'h0000, 0, fa, ud);
    check("t5_wrap_addr", {16'h0, fa}, 32'h0000_0000);
    reset_dut(16'hFFFF);
    do_instr(16'hCA11, C_CALL, 16'h0100, 0, fa, ud);
    do_instr(16'h4E7F, C_RET, 16'h0000, 0, fa, ud);
    check("t5_ret_addr", {16'h0, fa}, 32'h0000_0100);
    check("t5_ret_d", {16'h0, ud}, 32'h0000_0000);

    // Asynchronous reset in FETCH with two return addresses stacked.
    reset_dut(16'h0000);
    do_instr(16'hCA11, C_CALL, 16'h0040, 0, fa, ud);
    do_instr(16'hCA11, C_CALL, 16'h0080, 0, fa, ud);
    check("t6_req_before", {31'd0, bus.mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_req_async", {31'd0, bus.mem_req}, 32'd0);
    check("t6_fault_async", {31'd0, bus.fault}, 32'd0);
    check("t6_addr_async", {16'h0, bus.mem_addr}, 32'd0);
    reset_dut(16'h0000);
    do_instr(16'h4E7F, C_RET, 16'h0000, 0, fa, ud);
    check("t6_sp_cleared", {31'd0, bus.fault}, 32'd1);
    check_halted(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
